// File: rtl/led_pattern_ring.sv
// Purpose : N-stage circular LED pattern sequencer. Modes: rotate up, rotate down, bounce, hold.
// Latency : q and step are registered. With interval=K, q steps on the Kth enabled edge after count=0.
// Backpr. : none. en=0 freezes the counter, q and bounce state. load overrides a coincident step.
//
// Ports:
//   clk          rising-edge clock for all logic
//   rst          synchronous active-high reset (highest priority)
//   en           1 = interval counter runs, 0 = everything frozen
//   mode         00 rotate up, 01 rotate down, 10 bounce, 11 hold
//   interval     cycles per step (0 behaves like 1)
//   load         one-cycle request to load load_pattern (beats a step)
//   load_pattern pattern written on load
//   q            registered pattern, q[0] is the first LED
//   step         one-cycle pulse in the cycle q shows a newly stepped value
module led_pattern_ring #(
  parameter int                 N_OUT        = 6,
  parameter int                 CNT_W        = 24,
  parameter logic [N_OUT-1:0]   INIT_PATTERN = 6'b000111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] interval,
  input  logic             load,
  input  logic [N_OUT-1:0] load_pattern,
  output logic [N_OUT-1:0] q,
  output logic             step
);

  localparam int BC_W = (N_OUT > 2) ? $clog2(N_OUT) : 1;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DN     = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  logic [CNT_W-1:0] count, count_nxt;
  logic [N_OUT-1:0] q_nxt;
  logic             step_nxt;
  dir_t             bounce_dir, bounce_dir_nxt;
  logic [BC_W-1:0]  bounce_cnt, bounce_cnt_nxt;

  logic [CNT_W-1:0] ivl_m1;
  logic             tc;
  logic [N_OUT-1:0] rot_up, rot_dn;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= INIT_PATTERN;
      count      <= '0;
      step       <= 1'b0;
      bounce_dir <= DIR_UP;
      bounce_cnt <= '0;
    end else begin
      q          <= q_nxt;
      count      <= count_nxt;
      step       <= step_nxt;
      bounce_dir <= bounce_dir_nxt;
      bounce_cnt <= bounce_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // interval==0 behaves like 1, so the terminal value is max(interval,1)-1.
    ivl_m1 = (interval == '0) ? '0 : interval - CNT_W'(1);
    // >= rather than == so that shrinking interval below the current count
    // terminates on the next cycle instead of wrapping the counter.
    tc     = en && (count >= ivl_m1);
    rot_up = {q[N_OUT-2:0], q[N_OUT-1]};
    rot_dn = {q[0], q[N_OUT-1:1]};

    q_nxt          = q;
    count_nxt      = count;
    step_nxt       = 1'b0;
    bounce_dir_nxt = bounce_dir;
    bounce_cnt_nxt = bounce_cnt;

    if (load) begin
      q_nxt          = load_pattern;
      count_nxt      = '0;
      bounce_dir_nxt = DIR_UP;
      bounce_cnt_nxt = '0;
    end else begin
      if (en) begin
        count_nxt = tc ? '0 : count + CNT_W'(1);
      end
      if (tc) begin
        step_nxt = 1'b1;
        case (mode)
          MODE_UP: q_nxt = rot_up;
          MODE_DN: q_nxt = rot_dn;
          MODE_BOUNCE: begin
            q_nxt = (bounce_dir == DIR_UP) ? rot_up : rot_dn;
            // The step at the far end still moves in the old direction, giving
            // N_OUT-1 steps per leg with no repeated end position.
            if (bounce_cnt == BC_W'(N_OUT - 2)) begin
              bounce_dir_nxt = (bounce_dir == DIR_UP) ? DIR_DN : DIR_UP;
              bounce_cnt_nxt = '0;
            end else begin
              bounce_cnt_nxt = bounce_cnt + BC_W'(1);
            end
          end
          default: q_nxt = q;  // hold: step still pulses, pattern and bounce state kept
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ring.sv
module tb_led_pattern_ring;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [23:0] interval = 24'd4;
  logic        load = 1'b0;
  logic [5:0]  load_pattern = 6'b0;
  logic [5:0]  q;
  logic        step;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_pattern_ring #(.N_OUT(6), .CNT_W(24), .INIT_PATTERN(6'b000111)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .interval     (interval),
    .load         (load),
    .load_pattern (load_pattern),
    .q            (q),
    .step         (step)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] interval;
    logic        load;
    logic [5:0]  lp;
    logic [5:0]  exp_q;
    logic        exp_step;
    logic [23:0] exp_count;
    string       tag;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string tag, input logic r, input logic e, input logic [1:0] m,
                     input logic [23:0] iv, input logic ld, input logic [5:0] lp,
                     input logic [5:0] eq, input logic es, input logic [23:0] ec);
    vec_t v;
    v.tag = tag; v.rst = r; v.en = e; v.mode = m; v.interval = iv; v.load = ld; v.lp = lp;
    v.exp_q = eq; v.exp_step = es; v.exp_count = ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  logic [5:0] up_seq [6];
  logic [5:0] bnc_seq [11];
  logic [5:0] prev;

  initial begin
    up_seq = '{6'b001110, 6'b011100, 6'b111000, 6'b110001, 6'b100011, 6'b000111};
    bnc_seq = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b010000,
                6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b000010};

    // Reset, then rotate up with interval 4 for a full 24-cycle revolution.
    add("reset", 1, 0, 2'b00, 24'd4, 0, 6'b0, 6'b000111, 0, 0);
    prev = 6'b000111;
    for (int s = 0; s < 6; s++) begin
      for (int c = 1; c <= 3; c++) add("rot_up_wait", 0, 1, 2'b00, 24'd4, 0, 6'b0, prev, 0, 24'(c));
      add("rot_up_step", 0, 1, 2'b00, 24'd4, 0, 6'b0, up_seq[s], 1, 0);
      prev = up_seq[s];
    end

    // Rotate down with interval 0: steps every cycle.
    add("rot_dn_iv0", 0, 1, 2'b01, 24'd0, 0, 6'b0, 6'b100011, 1, 0);
    add("rot_dn_iv0", 0, 1, 2'b01, 24'd0, 0, 6'b0, 6'b110001, 1, 0);
    add("rot_dn_iv0", 0, 1, 2'b01, 24'd0, 0, 6'b0, 6'b111000, 1, 0);

    // Bounce a single lit bit end to end and back.
    add("bounce_load", 0, 1, 2'b10, 24'd1, 1, 6'b000001, 6'b000001, 0, 0);
    for (int s = 0; s < 11; s++) add("bounce", 0, 1, 2'b10, 24'd1, 0, 6'b0, bnc_seq[s], 1, 0);

    // Load colliding with the terminal cycle suppresses the step.
    add("coll_pre_load", 0, 1, 2'b00, 24'd4, 1, 6'b000111, 6'b000111, 0, 0);
    for (int c = 1; c <= 3; c++) add("coll_wait", 0, 1, 2'b00, 24'd4, 0, 6'b0, 6'b000111, 0, 24'(c));
    add("coll_load", 0, 1, 2'b00, 24'd4, 1, 6'b101010, 6'b101010, 0, 0);
    for (int c = 1; c <= 3; c++) add("coll_after", 0, 1, 2'b00, 24'd4, 0, 6'b0, 6'b101010, 0, 24'(c));
    add("coll_step", 0, 1, 2'b00, 24'd4, 0, 6'b0, 6'b010101, 1, 0);

    // Enable freeze at count 2, then hold mode.
    add("en_run", 0, 1, 2'b00, 24'd4, 0, 6'b0, 6'b010101, 0, 1);
    add("en_run", 0, 1, 2'b00, 24'd4, 0, 6'b0, 6'b010101, 0, 2);
    for (int c = 0; c < 10; c++) add("en_frozen", 0, 0, 2'b00, 24'd4, 0, 6'b0, 6'b010101, 0, 2);
    add("en_resume", 0, 1, 2'b00, 24'd4, 0, 6'b0, 6'b010101, 0, 3);
    add("en_resume_step", 0, 1, 2'b00, 24'd4, 0, 6'b0, 6'b101010, 1, 0);
    for (int s = 0; s < 2; s++) begin
      for (int c = 1; c <= 3; c++) add("hold_wait", 0, 1, 2'b11, 24'd4, 0, 6'b0, 6'b101010, 0, 24'(c));
      add("hold_step", 0, 1, 2'b11, 24'd4, 0, 6'b0, 6'b101010, 1, 0);
    end

    // Interval shrink below the current count, then reset beating load.
    add("shrink_load", 0, 1, 2'b00, 24'd100, 1, 6'b000111, 6'b000111, 0, 0);
    for (int c = 1; c <= 50; c++) add("shrink_count", 0, 1, 2'b00, 24'd100, 0, 6'b0, 6'b000111, 0, 24'(c));
    add("shrink_step", 0, 1, 2'b00, 24'd10, 0, 6'b0, 6'b001110, 1, 0);
    add("post_shrink", 0, 1, 2'b00, 24'd10, 0, 6'b0, 6'b001110, 0, 1);
    add("rst_vs_load", 1, 1, 2'b00, 24'd10, 1, 6'b101010, 6'b000111, 0, 0);
    add("after_rst", 0, 1, 2'b00, 24'd10, 0, 6'b0, 6'b000111, 0, 1);

    foreach (vq[i]) begin
      rst = vq[i].rst; en = vq[i].en; mode = vq[i].mode; interval = vq[i].interval;
      load = vq[i].load; load_pattern = vq[i].lp;
      @(posedge clk); #1;
      chk({vq[i].tag, "_q"},     32'(q),         32'(vq[i].exp_q));
      chk({vq[i].tag, "_step"},  32'(step),      32'(vq[i].exp_step));
      chk({vq[i].tag, "_count"}, 32'(dut.count), 32'(vq[i].exp_count));
    end

    // Latency from reset: interval 7 must step on exactly the 7th edge.
    begin
      bit seen = 0;
      int lat = 0;
      rst = 1; load = 0; en = 0; interval = 24'd7; mode = 2'b00;
      @(posedge clk); #1;
      rst = 0; en = 1;
      for (int c = 1; c <= 20 && !seen; c++) begin
        @(posedge clk); #1;
        if (step) begin seen = 1; lat = c; end
      end
      chk("lat_seen", 32'(seen), 32'd1);
      chk("lat_edges", 32'(lat), 32'd7);
      chk("lat_q", 32'(q), 32'(6'b001110));
      @(posedge clk); #1;
      chk("lat_pulse_one_cycle", 32'(step), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_ring.md
Name: led_pattern_ring

Overview:
- Parametrised N-stage circular pattern sequencer for the LED chain in the rainbow-lights design.
- Advances a bit pattern one position every programmable number of clock cycles.
- Modes: rotate up, rotate down, bounce (ping-pong), hold.
- Adds a runtime pattern load, an enable, and a step strobe so downstream colour and PWM logic can synchronise to each step.

Parameters:
- N_OUT, 6, number of pattern stages/outputs (≥2).
- CNT_W, 24, width of interval counter and interval input.
- INIT_PATTERN, 6'b000111 ({N_OUT} bits), pattern on q after reset.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = interval counter runs; 0 = counter and pattern frozen
- mode  in  2  00 rotate up, 01 rotate down, 10 bounce, 11 hold
- interval  in  CNT_W  cycles per step; 0 treated as 1
- load  in  1  single-cycle request to load load_pattern
- load_pattern  in  N_OUT  pattern written on load
- q  out  N_OUT  registered pattern; q[0] is first LED
- step  out  1  registered one-cycle pulse, high in the cycle q shows a new stepped value

Behaviour:
- Reset: synchronous; rst=1 at a clk edge sets the following, overriding all other inputs:
  - q = INIT_PATTERN
  - count = 0
  - step = 0
  - bounce_dir = up
  - bounce_cnt = 0
- Terminal condition: tc = en && (count >= max(interval,1) − 1).
  - Uses >= so that lowering interval mid-count steps on the next cycle instead of wrapping 2^CNT_W.
- Counter:
  - If en=0: count holds.
  - Else if tc: count <= 0.
  - Else: count <= count + 1.
  - No overflow is possible because the compare is >=.
- Step: on a tc edge (and no load), q updates and step <= 1 at that same edge. Otherwise step <= 0.
  - Latency: with interval=K and en held high from count=0, q changes at the Kth edge.
- Rotate up (00): q[i] <= q[i−1] for i≥1; q[0] <= q[N_OUT−1].
- Rotate down (01): q[i] <= q[i+1] for i<N_OUT−1; q[N_OUT−1] <= q[0].
- Bounce (10):
  - Rotates in bounce_dir.
  - bounce_cnt increments on each step.
  - When bounce_cnt reaches N_OUT−2 at a step: that step still rotates in the current direction, then bounce_dir flips and bounce_cnt <= 0.
  - Net effect: N_OUT−1 steps per direction, so a single lit bit walks 0 → N_OUT−1 → 0 without repeating an end position twice.
- Hold (11):
  - count still runs and step still pulses on tc; q unchanged.
  - bounce state is unchanged.
- Mode change:
  - Takes effect at the next step; count is not cleared.
  - Entering bounce from another mode keeps the existing bounce_dir/bounce_cnt.
- Load:
  - load=1 (rst=0) sets q <= load_pattern, count <= 0, bounce_dir <= up, bounce_cnt <= 0, step <= 0.
  - Priority is rst > load > step. A load coinciding with tc suppresses that step.
  - Load works regardless of en.
- en=0: no steps. q, count and bounce state hold. step = 0.
- interval change: takes effect immediately via the compare; no restart.
- Output: q is driven directly from registers, with no combinational path from inputs to q or step.

Test Plan:
- Reset/rotate up: rst 1 cycle; N_OUT=6, interval=4, en=1, mode=00. Expected:
  - q=000111 after reset.
  - q=001110 at the 4th edge, with step high exactly that cycle.
  - q=011100 at the 8th edge.
  - q=000111 again after 6 steps (24 cycles).
- Rotate down/interval 0: interval=0, mode=01, start 000111. Expected: step every cycle; q sequence 100011, 110001, 111000.
- Bounce: load 000001, interval=1, mode=10. Expected:
  - q sequence 000010, 000100, 001000, 010000, 100000, 010000, 001000, 000100, 000010, 000001, 000010.
  - The direction flips on reaching each end.
- Load vs step collision: interval=4; assert load=1 with load_pattern=101010 on the tc cycle. Expected:
  - q=101010, step=0, count=0.
  - Next step 4 cycles later gives q=010101 (mode 00).
- Enable/hold: deassert en at count=2 for 10 cycles. Expected: q and count are frozen and step=0; the step occurs 2 cycles after re-enable. In mode=11, step pulses every 4 cycles while q stays unchanged.
- Reset mid-operation/interval shrink: count=50 with interval=100; set interval=10. Expected:
  - The step fires on the next edge.
  - A later rst asserted together with load yields q=INIT_PATTERN, count=0, step=0.
